clock_time_hms: RTL and testbench

- BCD time-of-day keeper; consumes the 1 s enable pulse from the seconds divider.
- Counts seconds, minutes and hours in 24-hour format.
- Provides per-field time setting and carry pulses to downstream display and date logic.
- Sits between the 1 s counter stage and the 7-segment display driver.

---
 rtl/clock_time_hms.sv | 183 ++++++++++++++++++
 tb/tb_clock_time_hms.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_hms.sv
// clock_time_hms: BCD 24-hour time-of-day keeper.
// Advances on the 1 s enable while running, supports per-field writes with
// range validation, and emits registered minute/day carry pulses.
// Optional alarm comparator enabled by defining ALARM_EN.
module clock_time_hms #(
  parameter logic [7:0] INIT_H = 8'h00,
  parameter logic [7:0] INIT_M = 8'h00,
  parameter logic [7:0] INIT_S = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       run,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic [7:0] set_data,
  output logic       set_err,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       min_carry,
  output logic       day_carry
`ifdef ALARM_EN
  ,
  input  logic       alarm_set,
  input  logic [7:0] alarm_h,
  input  logic [7:0] alarm_m,
  input  logic       alarm_on,
  output logic       alarm_hit
`endif
);

  // A value is legal BCD for a field when both digits are decimal and it
  // does not exceed the field limit (BCD order matches binary order).
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

  // BCD increment without wrap; the caller handles the field limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [7:0] sec_q,  sec_d;
  logic [7:0] min_q,  min_d;
  logic [7:0] hour_q, hour_d;
  logic       set_err_q,   set_err_d;
  logic       min_carry_q, min_carry_d;
  logic       day_carry_q, day_carry_d;
  logic       advance_s;

`ifdef ALARM_EN
  logic [7:0] alarm_h_q, alarm_h_d;
  logic [7:0] alarm_m_q, alarm_m_d;
  logic       alarm_hit_q, alarm_hit_d;
`endif

  // Next-state: field write has priority and swallows a coincident tick.
  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    set_err_d   = 1'b0;
    min_carry_d = 1'b0;
    day_carry_d = 1'b0;
    advance_s   = tick_1s & run & ~set_en;
    if (set_en) begin
      case (set_sel)
        2'd0: begin
          if (bcd_ok(set_data, 8'h59)) sec_d = set_data;
          else                         set_err_d = 1'b1;
        end
        2'd1: begin
          if (bcd_ok(set_data, 8'h59)) min_d = set_data;
          else                         set_err_d = 1'b1;
        end
        2'd2: begin
          if (bcd_ok(set_data, 8'h23)) hour_d = set_data;
          else                         set_err_d = 1'b1;
        end
        default: set_err_d = 1'b1;
      endcase
    end else if (advance_s) begin
      if (sec_q == 8'h59) begin
        sec_d       = 8'h00;
        min_carry_d = 1'b1;
        if (min_q == 8'h59) begin
          min_d = 8'h00;
          if (hour_q == 8'h23) begin
            hour_d      = 8'h00;
            day_carry_d = 1'b1;
          end else begin
            hour_d = bcd_inc(hour_q);
          end
        end else begin
          min_d = bcd_inc(min_q);
        end
      end else begin
        sec_d = bcd_inc(sec_q);
      end
    end else begin
      sec_d = sec_q;
    end
  end

`ifdef ALARM_EN
  // Alarm storage/validation and match detection on a counted :00 entry.
  always_comb begin
    alarm_h_d   = alarm_h_q;
    alarm_m_d   = alarm_m_q;
    alarm_hit_d = 1'b0;
    if (alarm_set) begin
      if (bcd_ok(alarm_h, 8'h23) && bcd_ok(alarm_m, 8'h59)) begin
        alarm_h_d = alarm_h;
        alarm_m_d = alarm_m;
      end else begin
        alarm_h_d = alarm_h_q;
      end
    end else begin
      alarm_h_d = alarm_h_q;
    end
    if (alarm_on && advance_s && (sec_q == 8'h59) &&
        (min_d == alarm_m_q) && (hour_d == alarm_h_q)) begin
      alarm_hit_d = 1'b1;
    end else begin
      alarm_hit_d = 1'b0;
    end
  end

  // Alarm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_h_q   <= 8'h00;
      alarm_m_q   <= 8'h00;
      alarm_hit_q <= 1'b0;
    end else begin
      alarm_h_q   <= alarm_h_d;
      alarm_m_q   <= alarm_m_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign alarm_hit = alarm_hit_q;
`endif

  // Time and pulse registers; an invalid alarm load also raises set_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= INIT_S;
      min_q       <= INIT_M;
      hour_q      <= INIT_H;
      set_err_q   <= 1'b0;
      min_carry_q <= 1'b0;
      day_carry_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
`ifdef ALARM_EN
      set_err_q   <= set_err_d |
                     (alarm_set & ~(bcd_ok(alarm_h, 8'h23) & bcd_ok(alarm_m, 8'h59)));
`else
      set_err_q   <= set_err_d;
`endif
      min_carry_q <= min_carry_d;
      day_carry_q <= day_carry_d;
    end
  end

  assign sec_bcd   = sec_q;
  assign min_bcd   = min_q;
  assign hour_bcd  = hour_q;
  assign set_err   = set_err_q;
  assign min_carry = min_carry_q;
  assign day_carry = day_carry_q;

endmodule

// File: tb/tb_clock_time_hms.sv
// Scoreboard bench for clock_time_hms (INIT = 12:34:56).
// Driver pushes hand-computed expected state per cycle; monitor pops and
// compares one cycle after each active edge. Alarm tests need ALARM_EN.
module tb_clock_time_hms;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1s = 1'b0;
  logic       run = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic [7:0] set_data = 8'h00;
  logic       set_err;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic       min_carry, day_carry;
  logic       alarm_set_s = 1'b0;
  logic [7:0] alarm_h_s = 8'h00;
  logic [7:0] alarm_m_s = 8'h00;
  logic       alarm_on_s = 1'b0;
  logic       alarm_hit_s;

  typedef struct {
    string      nm;
    logic [7:0] h, m, s;
    logic       err, mc, dc, hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  clock_time_hms #(.INIT_H(8'h12), .INIT_M(8'h34), .INIT_S(8'h56)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .run(run),
    .set_en(set_en), .set_sel(set_sel), .set_data(set_data),
    .set_err(set_err), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
    .hour_bcd(hour_bcd), .min_carry(min_carry), .day_carry(day_carry)
`ifdef ALARM_EN
    , .alarm_set(alarm_set_s), .alarm_h(alarm_h_s), .alarm_m(alarm_m_s),
    .alarm_on(alarm_on_s), .alarm_hit(alarm_hit_s)
`endif
  );

`ifndef ALARM_EN
  assign alarm_hit_s = 1'b0;
`endif

  // Monitor: compare the registered outputs against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (hour_bcd === e.h && min_bcd === e.m && sec_bcd === e.s &&
          set_err === e.err && min_carry === e.mc && day_carry === e.dc &&
          alarm_hit_s === e.hit) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %h:%h:%h err=%b mc=%b dc=%b hit=%b, want %h:%h:%h err=%b mc=%b dc=%b hit=%b",
                 e.nm, hour_bcd, min_bcd, sec_bcd, set_err, min_carry, day_carry, alarm_hit_s,
                 e.h, e.m, e.s, e.err, e.mc, e.dc, e.hit);
      end
    end
  end

  // One stimulus cycle plus the expected state after the following edge.
  task automatic cyc(input logic t, input logic se, input logic [1:0] sel,
                     input logic [7:0] d, input logic as,
                     input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                     input logic eerr, input logic emc, input logic edc,
                     input logic ehit, input string nm);
    exp_t e;
    @(negedge clk);
    tick_1s     = t;
    set_en      = se;
    set_sel     = sel;
    set_data    = d;
    alarm_set_s = as;
    e.nm = nm; e.h = eh; e.m = em; e.s = es;
    e.err = eerr; e.mc = emc; e.dc = edc; e.hit = ehit;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                      input string nm);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, eh, em, es, 1'b0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic tick(input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                      input logic emc, input logic edc, input logic ehit, input string nm);
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, eh, em, es, 1'b0, emc, edc, ehit, nm);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d,
                    input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                    input logic eerr, input string nm);
    cyc(1'b0, 1'b1, sel, d, 1'b0, eh, em, es, eerr, 1'b0, 1'b0, 1'b0, nm);
  endtask

  logic [7:0] t1_s [5] = '{8'h57, 8'h58, 8'h59, 8'h00, 8'h01};
  logic [7:0] t1_m [5] = '{8'h34, 8'h34, 8'h34, 8'h35, 8'h35};
  logic       t1_mc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // reset state
    idle(8'h12, 8'h34, 8'h56, "reset");
    idle(8'h12, 8'h34, 8'h56, "reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;

    // five ticks spaced ten cycles apart
    for (int i = 0; i < 5; i++) begin
      tick(8'h12, t1_m[i], t1_s[i], t1_mc[i], 1'b0, 1'b0, "tick_seq");
      for (int j = 0; j < 9; j++) idle(8'h12, t1_m[i], t1_s[i], "tick_gap");
    end

    // set to 23:59:58 and roll over the day
    wr(2'd2, 8'h23, 8'h23, 8'h35, 8'h01, 1'b0, "set_hour");
    wr(2'd1, 8'h59, 8'h23, 8'h59, 8'h01, 1'b0, "set_min");
    wr(2'd0, 8'h58, 8'h23, 8'h59, 8'h58, 1'b0, "set_sec_no_carry");
    tick(8'h23, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, "to_235959");
    tick(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "day_wrap");
    idle(8'h00, 8'h00, 8'h00, "day_wrap_pulse_end");

    // rejected writes
    wr(2'd0, 8'h60, 8'h00, 8'h00, 8'h00, 1'b1, "bad_sec_60");
    idle(8'h00, 8'h00, 8'h00, "err_one_cycle");
    wr(2'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1, "bad_min_5a");
    idle(8'h00, 8'h00, 8'h00, "err_one_cycle");
    wr(2'd2, 8'h24, 8'h00, 8'h00, 8'h00, 1'b1, "bad_hour_24");
    idle(8'h00, 8'h00, 8'h00, "err_one_cycle");
    wr(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, "bad_sel_3");
    idle(8'h00, 8'h00, 8'h00, "err_one_cycle");

    // set collides with tick: tick dropped
    wr(2'd0, 8'h05, 8'h00, 8'h00, 8'h05, 1'b0, "set_sec_05");
    cyc(1'b1, 1'b1, 2'd1, 8'h10, 1'b0, 8'h00, 8'h10, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0,
        "set_vs_tick");

    // hold while stopped, then resume
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(8'h00, 8'h10, 8'h05, 1'b0, 1'b0, 1'b0, "run0_frozen");
      idle(8'h00, 8'h10, 8'h05, "run0_gap");
    end
    run = 1'b1;
    tick(8'h00, 8'h10, 8'h06, 1'b0, 1'b0, 1'b0, "run1_tick");
    tick(8'h00, 8'h10, 8'h07, 1'b0, 1'b0, 1'b0, "held_tick_a");
    tick(8'h00, 8'h10, 8'h08, 1'b0, 1'b0, 1'b0, "held_tick_b");

    // hour units 9 -> tens carry
    wr(2'd2, 8'h09, 8'h09, 8'h10, 8'h08, 1'b0, "set_h09");
    wr(2'd1, 8'h59, 8'h09, 8'h59, 8'h08, 1'b0, "set_m59");
    wr(2'd0, 8'h59, 8'h09, 8'h59, 8'h59, 1'b0, "set_s59");
    tick(8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "hour_09_to_10");
    tick(8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, "after_hour_carry");

`ifdef ALARM_EN
    // armed alarm at 07:00
    alarm_h_s = 8'h07; alarm_m_s = 8'h00; alarm_on_s = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0,
        "alarm_load");
    wr(2'd2, 8'h06, 8'h06, 8'h00, 8'h01, 1'b0, "a_set_h");
    wr(2'd1, 8'h59, 8'h06, 8'h59, 8'h01, 1'b0, "a_set_m");
    wr(2'd0, 8'h58, 8'h06, 8'h59, 8'h58, 1'b0, "a_set_s");
    tick(8'h06, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, "a_tick1");
    tick(8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "alarm_hit");
    idle(8'h07, 8'h00, 8'h00, "alarm_hit_end");
    // disarmed
    alarm_on_s = 1'b0;
    wr(2'd2, 8'h06, 8'h06, 8'h00, 8'h00, 1'b0, "b_set_h");
    wr(2'd1, 8'h59, 8'h06, 8'h59, 8'h00, 1'b0, "b_set_m");
    wr(2'd0, 8'h58, 8'h06, 8'h59, 8'h58, 1'b0, "b_set_s");
    tick(8'h06, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, "b_tick1");
    tick(8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "alarm_off_no_hit");
    // manual set onto the match
    alarm_on_s = 1'b1;
    wr(2'd0, 8'h59, 8'h07, 8'h00, 8'h59, 1'b0, "c_set_s");
    wr(2'd0, 8'h00, 8'h07, 8'h00, 8'h00, 1'b0, "manual_set_no_hit");
    idle(8'h07, 8'h00, 8'h00, "manual_set_quiet");
    // invalid alarm value
    alarm_h_s = 8'h24;
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0,
        "bad_alarm");
    idle(8'h07, 8'h00, 8'h00, "bad_alarm_end");
`endif

    // drain check: every expectation must have been consumed
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
